// File: rtl/cordic_serial_stage.sv
// One CORDIC micro-rotation on bit-serial operands.
// X, Y and A arrive LSB-first as SW-bit slices over N = DW/SW beats. One
// cycle is spent combining them, and the results stream back out LSB-first
// over the next N beats. Mode, Stg, Atan and ISin are captured with the
// frame-start strobe. The result stream has its own shift registers, so
// the next frame can load while the previous result is still going out.
// DW must be an integer multiple of SW.
module cordic_serial_stage #(
    parameter int DW         = 12,
    parameter int SW         = 2,
    parameter int SHW        = 3,
    parameter int ONE_OVER_K = 1242
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           Rdy,
    input  logic           Mode,
    input  logic [SHW-1:0] Stg,
    input  logic [DW-1:0]  Atan,
    input  logic [SW-1:0]  Xin,
    input  logic [SW-1:0]  Yin,
    input  logic [SW-1:0]  Ain,
    input  logic           ISin,
    output logic [SW-1:0]  Xout,
    output logic [SW-1:0]  Yout,
    output logic [SW-1:0]  Aout,
    output logic           ISout,
    output logic           Vld,
    output logic           Busy,
    output logic           Err
);

    // Beats per word, and widths of the beat counter and the output counter.
    localparam int N  = DW / SW;
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    // Stage-0 seed, already reduced to the word width.
    localparam logic signed [DW-1:0] K_W = DW'(ONE_OVER_K);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [BW-1:0]   beat_reg;
    logic [BW-1:0]   beat_next;

    // Frame control captured together with the start strobe.
    logic            mode_reg;
    logic [SHW-1:0]  stg_reg;
    logic [DW-1:0]   atan_reg;
    logic            is_cap_reg;

    // Assembled input words (built from the per-slice registers below).
    logic [DW-1:0]   x_word;
    logic [DW-1:0]   y_word;
    logic [DW-1:0]   a_word;

    // Combinational results of the micro-rotation.
    logic signed [DW-1:0] x_res;
    logic signed [DW-1:0] y_res;
    logic signed [DW-1:0] a_res;

    // Output shift registers and the count of result beats still to send.
    logic [DW-1:0]   xo_reg;
    logic [DW-1:0]   yo_reg;
    logic [DW-1:0]   ao_reg;
    logic [CW-1:0]   out_cnt_reg;
    logic            isout_reg;
    logic            err_reg;

    logic            accept;
    logic            reject;

    // A strobe is only honoured while idle; anywhere else it is an error.
    assign accept = Rdy && (state_reg == IDLE);
    assign reject = Rdy && (state_reg != IDLE);

    // Arithmetic shift with sign fill; shifting by DW or more leaves only sign bits.
    function automatic logic signed [DW-1:0] shr(input logic signed [DW-1:0] v,
                                                  input logic [SHW-1:0] s);
        if (int'(s) >= DW) begin
            shr = {DW{v[DW-1]}};
        end else begin
            shr = v >>> s;
        end
    endfunction

    // State and beat counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
        end
    end

    // Next-state logic: slice 0 arrives with the strobe, so LOAD continues from beat 1.
    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        case (state_reg)
            IDLE: begin
                if (Rdy) begin
                    state_next = (N > 1) ? LOAD : CALC;
                    beat_next  = BW'(1 % N);
                end
            end
            LOAD: begin
                if (beat_reg == BW'(N - 1)) begin
                    state_next = CALC;
                    beat_next  = '0;
                end else begin
                    beat_next  = beat_reg + BW'(1);
                end
            end
            CALC: begin
                state_next = IDLE;
                beat_next  = '0;
            end
            default: begin
                state_next = IDLE;
                beat_next  = '0;
            end
        endcase
    end

    // Capture the per-frame controls with the accepted strobe only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_reg   <= 1'b0;
            stg_reg    <= '0;
            atan_reg   <= '0;
            is_cap_reg <= 1'b0;
        end else if (accept) begin
            mode_reg   <= Mode;
            stg_reg    <= Stg;
            atan_reg   <= Atan;
            is_cap_reg <= ISin;
        end
    end

    // One register per input slice; slice k is written only on beat k of the frame.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            logic          slice_en;
            logic [SW-1:0] xs_reg;
            logic [SW-1:0] ys_reg;
            logic [SW-1:0] as_reg;

            if (gi == 0) begin : g_first
                assign slice_en = accept;
            end else begin : g_rest
                assign slice_en = (state_reg == LOAD) && (beat_reg == BW'(gi));
            end

            // Slice capture for this beat position.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    xs_reg <= '0;
                    ys_reg <= '0;
                    as_reg <= '0;
                end else if (slice_en) begin
                    xs_reg <= Xin;
                    ys_reg <= Yin;
                    as_reg <= Ain;
                end
            end

            assign x_word[gi*SW +: SW] = xs_reg;
            assign y_word[gi*SW +: SW] = ys_reg;
            assign a_word[gi*SW +: SW] = as_reg;
        end
    endgenerate

    // The micro-rotation; all arithmetic wraps at DW bits.
    always_comb begin
        logic signed [DW-1:0] xw;
        logic signed [DW-1:0] yw;
        logic signed [DW-1:0] aw;
        logic signed [DW-1:0] xs;
        logic signed [DW-1:0] ys;
        logic                 d_pos;

        xw    = $signed(x_word);
        yw    = $signed(y_word);
        aw    = $signed(a_word);
        xs    = shr(xw, stg_reg);
        ys    = shr(yw, stg_reg);
        // Rotation steers A toward zero; vectoring steers Y toward zero.
        d_pos = mode_reg ? yw[DW-1] : ~aw[DW-1];

        if (d_pos) begin
            x_res = xw - ys;
            y_res = yw + xs;
            a_res = aw - $signed(atan_reg);
        end else begin
            x_res = xw + ys;
            y_res = yw - xs;
            a_res = aw + $signed(atan_reg);
        end

        // The first rotation stage seeds the vector with the gain-compensated constant.
        if (!mode_reg && (stg_reg == '0)) begin
            x_res = K_W;
            y_res = d_pos ? K_W : -K_W;
        end
    end

    // Result shift registers: load at the end of CALC, then shift one slice per beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xo_reg      <= '0;
            yo_reg      <= '0;
            ao_reg      <= '0;
            out_cnt_reg <= '0;
            isout_reg   <= 1'b0;
        end else if (state_reg == CALC) begin
            xo_reg      <= x_res;
            yo_reg      <= y_res;
            ao_reg      <= a_res;
            out_cnt_reg <= CW'(N);
            isout_reg   <= is_cap_reg;
        end else if (out_cnt_reg != '0) begin
            xo_reg      <= xo_reg >> SW;
            yo_reg      <= yo_reg >> SW;
            ao_reg      <= ao_reg >> SW;
            out_cnt_reg <= out_cnt_reg - CW'(1);
        end
    end

    // Sticky error flag for strobes that arrive while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (reject) begin
            err_reg <= 1'b1;
        end
    end

    assign Vld   = (out_cnt_reg != '0);
    assign Xout  = Vld ? xo_reg[SW-1:0] : '0;
    assign Yout  = Vld ? yo_reg[SW-1:0] : '0;
    assign Aout  = Vld ? ao_reg[SW-1:0] : '0;
    assign ISout = isout_reg;
    assign Busy  = (state_reg != IDLE);
    assign Err   = err_reg;

endmodule
